counting_gen: RTL
=================

Name: counting_gen

Overview:
- Symbol-stream transmitter for the 2-bit `num` counting protocol.
- Generates one frame per request: a run of 01, then a run of 10, then a run of 11, then a single 00 terminator.
- A downstream `num` consumer (the counting detector) therefore sees its match condition for exactly the 11 run.
- Sits upstream of the detector as a stimulus/pattern source. Run lengths are programmed per frame.

Parameters:
- LEN_W, 4, width of each run-length field; maximum run length is 2^LEN_W-1.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  frame request; sampled only in IDLE.
- len_a  input  LEN_W  number of 01 symbols; latched on accepted start.
- len_b  input  LEN_W  number of 10 symbols; latched on accepted start.
- len_c  input  LEN_W  number of 11 symbols; latched on accepted start.
- abort  input  1  terminate current frame early.
- num  output  2  transmitted symbol, registered.
- busy  output  1  high from the cycle after an accepted start through the terminator cycle.
- done  output  1  one-cycle pulse coincident with the terminator symbol of a completed frame.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, num=00, busy=0, done=0, counter=0, latched lengths=0.
- All outputs are registered; no combinational path from inputs to outputs.
- States and symbols emitted:
  - IDLE: num=00.
  - RUN_A: num=01.
  - RUN_B: num=10.
  - RUN_C: num=11.
  - TERM: num=00.
- IDLE, start=1 at edge k:
  - Latch len_a/len_b/len_c.
  - Enter RUN_A; num=01 and busy=1 visible after edge k (latency 1 cycle).
  - start=0: stay in IDLE.
- Length clamp: a latched length of 0 is treated as 1; every run emits at least one symbol.
- Counting: a down-counter loads the clamped run length on entry to each RUN state and decrements every cycle.
  - When the counter reaches 1, the next edge advances RUN_A->RUN_B->RUN_C->TERM, loading the next length.
  - Each run occupies exactly its clamped length in cycles. No 00 or gap cycles between runs.
- TERM: lasts exactly 1 cycle.
  - done=1, busy=1 during this cycle.
  - Next edge -> IDLE, busy=0, done=0.
  - start is not sampled in TERM; frames are separated by at least one IDLE cycle, so the minimum frame period is len_a+len_b+len_c+2 cycles.
- start while busy (any RUN or TERM state): ignored, not queued. Latched lengths are unchanged.
- abort=1 in any RUN state: next edge enters TERM with num=00, busy=1, done=0.
  - Then IDLE as normal. Aborted frames never pulse done.
  - abort in IDLE or TERM: no effect.
  - abort and start both high in IDLE: start wins (abort ignored in IDLE).
- Input changes to len_* while busy have no effect on the current frame.
- Reset asserted mid-frame: immediate return to IDLE, num=00, busy=0, done=0. No terminator or done is emitted.
- Counter width: LEN_W bits. The maximum run of 2^LEN_W-1 must not wrap.

Test Plan:
- Reset then start with len_a=2, len_b=3, len_c=1 -> num sequence after the start edge is 01,01,10,10,10,11,00(done=1) then 00 idle. busy high for 7 cycles, done high for exactly 1 cycle.
- len_a=0, len_b=0, len_c=0 -> num 01,10,11,00. done pulses on the 4th cycle, same as all lengths=1.
- LEN_W=4, all lengths=15 -> 15×01, 15×10, 15×11, 00. Total busy 46 cycles, no counter wrap.
- Start pulsed again during RUN_B with different lengths -> ignored. The current frame completes with the original lengths; the next frame starts only after a new start in IDLE.
- abort asserted on the 2nd cycle of RUN_B (lengths 2,3,2) -> num 01,01,10,10,00 with done=0 throughout, then IDLE, busy=0.
- rst_n pulled low asynchronously mid-RUN_C -> num=00, busy=0 immediately, without waiting for a clock edge. After release, a fresh start produces a complete, correct frame.

Source files
------------

// File: rtl/counting_gen_if.sv
// rtl/counting_gen_if.sv - request/symbol bundle between a frame requester and counting_gen
//   start, len_a, len_b, len_c, abort : requester -> generator
//   num, busy, done                   : generator -> requester
//   master : requester side, slave : generator side

interface counting_gen_if #(
    parameter int LEN_W = 4
);
    logic             start;
    logic [LEN_W-1:0] len_a;
    logic [LEN_W-1:0] len_b;
    logic [LEN_W-1:0] len_c;
    logic             abort;
    logic [1:0]       num;
    logic             busy;
    logic             done;

    modport master (
        output start, len_a, len_b, len_c, abort,
        input  num, busy, done
    );

    modport slave (
        input  start, len_a, len_b, len_c, abort,
        output num, busy, done
    );
endinterface

// File: rtl/counting_gen.sv
// rtl/counting_gen.sv - frame generator emitting runs of 01, 10, 11 and a 00 terminator on num
//   clk   : system clock, all state changes on posedge
//   rst_n : asynchronous active-low reset
//   bus   : counting_gen_if slave
//           start          frame request, sampled only in IDLE
//           len_a/b/c      run lengths (0 treated as 1), captured on accepted start
//           abort          end the current frame early (RUN states only)
//           num            transmitted symbol, registered
//           busy           high from the cycle after accepted start through the terminator
//           done           one-cycle pulse on the terminator of a completed frame

module counting_gen #(
    parameter int LEN_W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    counting_gen_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN_A = 3'd1,
        RUN_B = 3'd2,
        RUN_C = 3'd3,
        TERM  = 3'd4
    } state_t;

    localparam logic [1:0] SYM_GAP = 2'b00;
    localparam logic [1:0] SYM_A   = 2'b01;
    localparam logic [1:0] SYM_B   = 2'b10;
    localparam logic [1:0] SYM_C   = 2'b11;

    localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

    state_t           state;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] len_b_q;
    logic [LEN_W-1:0] len_c_q;
    logic [1:0]       num_q;
    logic             busy_q;
    logic             done_q;

    // A zero length still produces one symbol, so every run is visible downstream.
    function automatic logic [LEN_W-1:0] clamp(input logic [LEN_W-1:0] len);
        return (len == '0) ? ONE : len;
    endfunction

    // The first run length goes straight into the counter on the accepting
    // edge; only the later two run lengths need holding registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            len_b_q <= '0;
            len_c_q <= '0;
            num_q   <= SYM_GAP;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    // abort has no meaning here; a simultaneous start is honoured.
                    if (bus.start) begin
                        len_b_q <= bus.len_b;
                        len_c_q <= bus.len_c;
                        cnt     <= clamp(bus.len_a);
                        state   <= RUN_A;
                        num_q   <= SYM_A;
                        busy_q  <= 1'b1;
                    end else begin
                        num_q  <= SYM_GAP;
                        busy_q <= 1'b0;
                    end
                end

                RUN_A: begin
                    if (bus.abort) begin
                        state <= TERM;
                        num_q <= SYM_GAP;
                        cnt   <= '0;
                    end else if (cnt == ONE) begin
                        state <= RUN_B;
                        num_q <= SYM_B;
                        cnt   <= clamp(len_b_q);
                    end else begin
                        cnt <= cnt - ONE;
                    end
                end

                RUN_B: begin
                    if (bus.abort) begin
                        state <= TERM;
                        num_q <= SYM_GAP;
                        cnt   <= '0;
                    end else if (cnt == ONE) begin
                        state <= RUN_C;
                        num_q <= SYM_C;
                        cnt   <= clamp(len_c_q);
                    end else begin
                        cnt <= cnt - ONE;
                    end
                end

                RUN_C: begin
                    if (bus.abort) begin
                        state <= TERM;
                        num_q <= SYM_GAP;
                        cnt   <= '0;
                    end else if (cnt == ONE) begin
                        // Natural end of frame: the terminator carries done.
                        state  <= TERM;
                        num_q  <= SYM_GAP;
                        done_q <= 1'b1;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt - ONE;
                    end
                end

                TERM: begin
                    // start is not looked at here, guaranteeing an IDLE gap between frames.
                    state  <= IDLE;
                    num_q  <= SYM_GAP;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end

                default: begin
                    state  <= IDLE;
                    cnt    <= '0;
                    num_q  <= SYM_GAP;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.num  = num_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule
